// File: rtl/mem_req_arbiter.sv
//==============================================================================
// Module  : mem_req_arbiter
// Brief   : Shares one external memory port among NUM_PORTS requesters and
//           routes in-order read responses back to the issuing port.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_req_arbiter_pkg;
  typedef logic [1:0] access_size_t;
endpackage

module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  req_valid_i,
  input  logic [NUM_PORTS-1:0]                  req_we_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata_i,
  input  access_size_t [NUM_PORTS-1:0]          req_size_i,
  output logic [NUM_PORTS-1:0]                  req_ready_o,
  output logic [NUM_PORTS-1:0]                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                 rsp_data_o,
  output logic                                  mem_rd_req_valid_o,
  output logic                                  mem_wr_req_valid_o,
  output logic [ADDR_WIDTH-1:0]                 mem_req_address_o,
  output logic [DATA_WIDTH-1:0]                 mem_wr_data_o,
  output access_size_t                          mem_req_access_size_o,
  input  logic                                  mem_req_ready_i,
  input  logic                                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]                 mem_rsp_data_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
  output logic                                  err_o
);

  localparam int c_id_w  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);

  logic [c_id_w-1:0]    r_rr_ptr;
  logic [c_id_w-1:0]    r_fifo [MAX_OUTSTANDING];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_stv_w-1:0]   r_starve [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                 r_err;

  logic                 w_full;
  logic [NUM_PORTS-1:0] w_elig;
  logic [NUM_PORTS-1:0] w_promoted;
  logic [c_id_w-1:0]    w_grant;
  logic                 w_any;
  logic                 w_gnt_we;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [c_id_w-1:0]    w_head;
  logic [NUM_PORTS-1:0] w_rsp_next;

  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] ptr);
    return (ptr == c_ptr_w'(MAX_OUTSTANDING - 1)) ? '0 : ptr + c_ptr_w'(1);
  endfunction

  // Fullness uses the registered count only, so a same-cycle pop frees nothing.
  assign w_full = (r_cnt == c_cnt_w'(MAX_OUTSTANDING));
  assign w_elig = req_valid_i & (req_we_i | {NUM_PORTS{~w_full}});

  always_comb begin
    w_promoted = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_promoted[p] = (ARB_MODE == 0) && (r_starve[p] == c_stv_w'(STARVE_LIMIT));
    end
  end

  // Descending scans let the last hit (lowest index / closest to rr_ptr) win.
  always_comb begin : p_grant
    int v_idx;
    v_idx   = 0;
    w_grant = '0;
    if (ARB_MODE == 0) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (w_elig[p]) w_grant = c_id_w'(p);
      end
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (w_elig[p] && w_promoted[p]) w_grant = c_id_w'(p);
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        v_idx = int'(r_rr_ptr) + i;
        if (v_idx >= NUM_PORTS) v_idx = v_idx - NUM_PORTS;
        if (w_elig[c_id_w'(v_idx)]) w_grant = c_id_w'(v_idx);
      end
    end
  end

  assign w_any    = |w_elig;
  assign w_gnt_we = req_we_i[w_grant];
  assign w_accept = w_any & mem_req_ready_i;
  assign w_push   = w_accept & ~w_gnt_we;
  assign w_pop    = mem_rsp_valid_i & (r_cnt != '0);
  assign w_head   = r_fifo[r_rd_ptr];

  assign mem_rd_req_valid_o    = w_any & ~w_gnt_we;
  assign mem_wr_req_valid_o    = w_any & w_gnt_we;
  assign mem_req_address_o     = w_any ? req_addr_i[w_grant]  : '0;
  assign mem_wr_data_o         = w_any ? req_wdata_i[w_grant] : '0;
  assign mem_req_access_size_o = w_any ? req_size_i[w_grant]  : '0;

  always_comb begin
    req_ready_o = '0;
    if (w_accept) req_ready_o[w_grant] = 1'b1;
  end

  always_comb begin
    w_rsp_next = '0;
    if (w_pop) w_rsp_next[w_head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_grant;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rr_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) r_starve[p] <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= (w_grant == c_id_w'(NUM_PORTS - 1)) ? '0 : w_grant + c_id_w'(1);
      end
      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
        2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_rsp_valid <= w_rsp_next;
      if (w_pop) r_rsp_data <= mem_rsp_data_i;
      if (mem_rsp_valid_i && (r_cnt == '0)) r_err <= 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!req_valid_i[p] || req_ready_o[p]) begin
          r_starve[p] <= '0;
        end else if (r_starve[p] != c_stv_w'(STARVE_LIMIT)) begin
          r_starve[p] <= r_starve[p] + c_stv_w'(1);
        end
      end
    end
  end

  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_data_o    = r_rsp_data;
  assign outstanding_o = r_cnt;
  assign err_o         = r_err;

endmodule

`default_nettype wire

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised arbiter that shares the single external memory port among NUM_PORTS requesters, such as fetch, the load/store stage and future ports like a second load unit or DMA. It generalises the fixed "fetch wins" steering in the CPU top. It supports two grant modes, fixed priority with anti-starvation promotion and round-robin, and a downstream ready handshake. Read responses are routed back to their originating port through an in-order ID FIFO supporting up to MAX_OUTSTANDING reads in flight.

## Interface
- NUM_PORTS, 2: number of requesters, 2..8; port 0 has the highest fixed priority.
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 32: data width.
- MAX_OUTSTANDING, 4: depth of the read-ID FIFO (power of two, ≥1).
- ARB_MODE, 0: 0 = fixed priority with starvation promotion, 1 = round-robin.
- STARVE_LIMIT, 8: in mode 0, consecutive cycles a port waits before it is promoted.

Ports (NP = NUM_PORTS):
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NP  per-port request valid.
- req_we_i  in  NP  1 = write, 0 = read.
- req_addr_i  in  NP×ADDR_WIDTH  per-port address.
- req_wdata_i  in  NP×DATA_WIDTH  per-port write data.
- req_size_i  in  NP×access_size_t  per-port access size.
- req_ready_o  out  NP  request accepted this cycle (one-hot or zero).
- rsp_valid_o  out  NP  read data valid for that port (one-hot or zero).
- rsp_data_o  out  DATA_WIDTH  read data, shared by all ports.
- mem_rd_req_valid_o  out  1  read request to memory.
- mem_wr_req_valid_o  out  1  write request to memory.
- mem_req_address_o  out  ADDR_WIDTH  address of the granted request.
- mem_wr_data_o  out  DATA_WIDTH  write data of the granted request.
- mem_req_access_size_o  out  access_size_t  access size of the granted request.
- mem_req_ready_i  in  1  memory accepts the request this cycle.
- mem_rsp_valid_i  in  1  read data returning from memory.
- mem_rsp_data_i  in  DATA_WIDTH  returning read data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  number of reads in flight.
- err_o  out  1  sticky error: a response arrived with no read outstanding.

## Operation
- Eligibility: port p is eligible when req_valid_i[p] is high and either req_we_i[p] = 1 or outstanding < MAX_OUTSTANDING. The full check uses the registered count only; a response popping in the same cycle does not free a slot.
- Grant selection is combinational and picks one eligible port g.
  - Mode 0: the lowest-index promoted eligible port wins. If no port is promoted, the lowest-index eligible port wins.
  - Mode 1: the first eligible port at or after rr_ptr, wrapping from NP-1 to 0.
- Memory outputs: mem_rd_req_valid_o = any eligible & ~req_we_i[g]; mem_wr_req_valid_o = any eligible & req_we_i[g]. Address, data and size are muxed from g. When idle, the address, data and size outputs hold 0.
- Acceptance: a request is accepted when a memory valid output and mem_req_ready_i are both high. On acceptance req_ready_o[g] = 1. Requesters hold all request fields stable until they see ready.
- On an accepted read, g is pushed into the ID FIFO and outstanding increments. An accepted write completes with no response.
- rr_ptr resets to 0. On each acceptance it becomes (g+1) mod NP.
- Starvation counter, one per port, saturating at STARVE_LIMIT:
  - increments when the port has valid high but is not accepted;
  - clears on acceptance or when valid is low.
  - The port is promoted while its counter equals STARVE_LIMIT.
  - Counters are unused in mode 1.
- Response path: on mem_rsp_valid_i with the FIFO non-empty, pop the head ID h. Next cycle, rsp_valid_o[h] = 1 and rsp_data_o = mem_rsp_data_i (registered). Outstanding decrements.
- Responses are strictly in order; the memory must return reads in issue order.
- mem_rsp_valid_i with the FIFO empty: the data is dropped, err_o is set, and it stays set until reset.
- Push and pop in the same cycle: both take effect and outstanding is unchanged.

## Timing
- Request path is combinational: req_* to mem_* and mem_req_ready_i to req_ready_o, zero latency.
- Response path latency is 1 cycle from mem_rsp_valid_i to rsp_valid_o.
- Reset (asynchronous on the falling edge of rst_i, released synchronously by design):
  - rr_ptr, the FIFO pointers, outstanding, starvation counters, rsp_valid_o, rsp_data_o and err_o all clear to 0.
  - Combinational outputs are 0 whenever all req_valid_i are low.
- Reset mid-operation drops any reads in flight. Responses from memory that arrive after reset therefore set err_o; the system must also reset memory.
- Throughput is one acceptance per cycle.

## Test plan
- Mode 0, NP=2: both ports request reads at 0x100 and 0x200 with ready=1 every cycle. Port 0 is granted; port 1 is granted in the first cycle after port 0 drops valid, or after 8 wait cycles if port 0 keeps requesting.
- Mode 1, NP=4: all ports hold valid with ready=1. Grants follow the order 0,1,2,3,0 with one req_ready_o per cycle.
- MAX_OUTSTANDING=2: issue reads from ports 1, 0 and 1 with no responses. The third read stalls (mem_rd_req_valid_o=0) while a write from port 0 is still accepted. Then return data 0xAA and 0xBB: rsp_valid_o[1] shows 0xAA and rsp_valid_o[0] shows 0xBB, each 1 cycle after its response.
- mem_req_ready_i=0 for 3 cycles with port 0 valid: no req_ready_o and the request is held stable. Acceptance occurs in the first cycle ready=1.
- mem_rsp_valid_i with outstanding=0: err_o goes high and stays high; rsp_valid_o stays 0.
- Assert rst_i low mid-burst with 2 reads outstanding: all registered outputs are 0 immediately and outstanding_o = 0.
